// File: rtl/fft_pkg.sv
// Shared constants for the FFT front end: mode encoding for the input
// demux and the default sample width / lane count used by its instances.
package fft_pkg;

  localparam logic MODE_SEL     = 1'b0;  // route to the explicit sel channel
  localparam logic MODE_RR      = 1'b1;  // round-robin across all channels
  localparam int   FFT_SAMPLE_W = 16;
  localparam int   FFT_LANES    = 4;

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register for a single demux output lane.
// 'load' writes d and marks the lane full. 'drain' is the consumer's ready;
// a full lane empties on drain unless it is reloaded in the same cycle.
// q keeps its last value after a drain.
module demux_chan_reg
  import fft_pkg::*;
#(
  parameter int N = FFT_SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         can_load
);

  logic [N-1:0] q_reg;
  logic         valid_reg;

  // Load takes priority so a drain and a reload in one cycle leave no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg     <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      q_reg     <= d;
      valid_reg <= 1'b1;
    end else if (drain) begin
      valid_reg <= 1'b0;
    end
  end

  assign q        = q_reg;
  assign valid    = valid_reg;
  assign can_load = ~valid_reg | drain;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-CH sample distributor with per-lane valid/ready.
// Samples go to the channel given by sel (mode=0; out-of-range sel maps to
// channel 0) or round-robin from channel 0 (mode=1). Round-robin order is
// strict: a busy target stalls the input instead of being skipped.
// Optional feature: define DEMUX_STREAM_SOF_EN to add in_sof (start of frame,
// forces channel 0 in round-robin) and the sticky short-frame flag sof_err.
module demux_stream
  import fft_pkg::*;
#(
  parameter int N     = FFT_SAMPLE_W,
  parameter int CH    = FFT_LANES,
  parameter int SEL_W = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
`ifdef DEMUX_STREAM_SOF_EN
  input  logic              in_sof,
  output logic              sof_err,
`endif
  output logic [CH*N-1:0]   out_data,
  output logic [CH-1:0]     out_valid,
  input  logic [CH-1:0]     out_ready,
  output logic              frame_done,
  output logic [SEL_W-1:0]  rr_ptr
);

  logic [SEL_W-1:0] rr_ptr_reg;
  logic             frame_done_reg;
  logic [SEL_W-1:0] tgt;
  logic             sof_hit;
  logic             accept;
  logic [CH-1:0]    load;
  logic [CH-1:0]    can_load;

`ifdef DEMUX_STREAM_SOF_EN
  assign sof_hit = (mode == MODE_RR) & in_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // Target decode: start-of-frame forces lane 0, else pointer or clamped sel.
  always_comb begin
    tgt = '0;
    if (sof_hit) begin
      tgt = '0;
    end else if (mode == MODE_RR) begin
      tgt = rr_ptr_reg;
    end else if ({1'b0, sel} < (SEL_W+1)'(CH)) begin
      tgt = sel;
    end
  end

  // Readiness depends only on the target lane, never on in_valid.
  assign in_ready = can_load[tgt];
  assign accept   = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      assign load[gi] = accept & (tgt == SEL_W'(gi));

      demux_chan_reg #(.N(N)) u_chan (
        .clk      (clk),
        .rst      (rst),
        .load     (load[gi]),
        .drain    (out_ready[gi]),
        .d        (in_data),
        .q        (out_data[gi*N +: N]),
        .valid    (out_valid[gi]),
        .can_load (can_load[gi])
      );
    end
  endgenerate

  // Round-robin pointer: parked at 0 outside round-robin, wraps with a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (mode == MODE_SEL) begin
        rr_ptr_reg <= '0;
      end else if (accept) begin
        if (sof_hit) begin
          rr_ptr_reg <= SEL_W'(1);
        end else if (rr_ptr_reg == SEL_W'(CH-1)) begin
          rr_ptr_reg     <= '0;
          frame_done_reg <= 1'b1;
        end else begin
          rr_ptr_reg <= rr_ptr_reg + SEL_W'(1);
        end
      end
    end
  end

`ifdef DEMUX_STREAM_SOF_EN
  logic sof_err_reg;

  // Sticky flag: a start-of-frame arrived before the previous frame completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_err_reg <= 1'b0;
    end else if (accept && sof_hit && (rr_ptr_reg != '0)) begin
      sof_err_reg <= 1'b1;
    end
  end

  assign sof_err = sof_err_reg;
`endif

  assign rr_ptr     = rr_ptr_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parametrised, registered 1-to-CH sample distributor with per-channel valid/ready handshake.
- Successor to the FFT input 1-to-4 combinational demux. Routes each input sample either to an explicitly selected channel or round-robin across all channels, filling butterfly input lanes.
- Sits between the sample source (ADC/test pattern) and the FFT butterfly stage inputs.
- Each channel owns a one-entry holding register, so the lanes can be drained independently.

Parameters:
- N, 16, sample width in bits.
- CH, 4, number of output channels (>=2).
- SEL_W, $clog2(CH), width of the explicit select.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N  input sample.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept in_data this cycle.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SEL_W  target channel when mode=0.
- out_data  output  CH*N  channel k occupies bits [k*N +: N].
- out_valid  output  CH  per-channel data valid.
- out_ready  input  CH  per-channel consumer ready.
- frame_done  output  1  one-cycle pulse when round-robin wraps.
- rr_ptr  output  SEL_W  current round-robin target (debug/status).

Behaviour:
- Reset (async, rst=1): out_data=0, out_valid=0, rr_ptr=0, frame_done=0. Any held samples are discarded, including mid-frame. After reset, the first round-robin sample goes to channel 0.
- Target channel tgt:
  - mode=0: tgt=sel; sel>=CH maps to channel 0.
  - mode=1: tgt=rr_ptr.
- in_ready = ~out_valid[tgt] | out_ready[tgt]. This is combinational from tgt and the channel state, and never depends on in_valid.
- Accept occurs when in_valid & in_ready. On the next clock edge:
  - slot[tgt] takes in_data;
  - out_valid[tgt] is set to 1.
  - Latency is 1 cycle; throughput is 1 sample/clk when the consumer keeps out_ready=1.
- Drain: when out_valid[k] & out_ready[k] and there is no accept into k, out_valid[k] clears next cycle.
  - Simultaneous drain and accept on the same channel: the new data is loaded and out_valid stays 1, with no bubble.
- out_data[k] is stable while out_valid[k]=1 and no drain occurs. After a drain it keeps the last value (it is not zeroed).
- Non-target channels are never modified by an accept.
- Round-robin pointer:
  - Increments on each accept in mode=1.
  - Wraps from CH-1 to 0; frame_done pulses for 1 cycle, registered with that accept.
  - While mode=0, rr_ptr is held at 0. Switching 1->0->1 therefore always restarts at channel 0.
  - A mode change mid-frame drops the partial frame position; already-held samples are not lost.
- Stall: if the target channel is full and not being drained, in_ready=0 and the pointer does not move. Round-robin order is strictly preserved (no skipping of busy channels).

Optional Feature:
- Macro: DEMUX_STREAM_SOF_EN.
- When defined, adds port in_sof (input, 1): start-of-frame marker, qualified by accept.
  - An accepted sample with in_sof=1 in mode=1 is routed to channel 0 regardless of rr_ptr. rr_ptr then becomes 1.
  - If rr_ptr was nonzero (short frame), frame_done does not pulse; a sticky output sof_err (1 bit) sets. sof_err clears only on rst.
  - in_ready is computed against channel 0 when in_sof=1.
- When undefined: there are no in_sof or sof_err ports, and the pointer advances purely by count.

Decomposition:
- Shared package fft_pkg:
  - mode encoding constants MODE_SEL=1'b0, MODE_RR=1'b1;
  - default sample width constant FFT_SAMPLE_W=16;
  - default lane count FFT_LANES=4.
- Sub-module demux_chan_reg holds one-entry register per channel, instantiated CH times in a generate loop:
  - inputs: load, drain, d;
  - outputs: q, valid, can_load.
- The top level holds tgt decode, rr_ptr, frame_done and in_ready mux.

Test Plan:
- Reset mid-stream:
  - stimulus: hold 3 samples, rr_ptr=3, assert rst asynchronously between edges;
  - response: out_valid=0000, out_data=0, rr_ptr=0 immediately, frame_done=0.
- Round-robin full rate:
  - stimulus: mode=1, out_ready=1111, send 0x0001..0x0008 back-to-back;
  - response: ch0 gets 0x0001 then 0x0005, ch3 gets 0x0004 then 0x0008, each 1 cycle after accept; frame_done pulses twice; in_ready stays 1.
- Back-pressure stall:
  - stimulus: mode=1, out_ready=0000, send 5 samples;
  - response: 4 accepted, out_valid=1111, in_ready=0 with rr_ptr=0; raising out_ready[0] accepts sample 5 into ch0 in the same cycle as the drain.
- Explicit select and out-of-range:
  - stimulus: mode=0, CH=3 build, sel=2 with 0xABCD, then sel=3 with 0x1234;
  - response: ch2=0xABCD, ch0=0x1234, rr_ptr stays 0.
- Simultaneous drain/load:
  - stimulus: ch1 full with 0x0011, out_ready[1]=1, accept 0x0022 to ch1 in the same cycle;
  - response: out_valid[1] stays 1, out_data ch1=0x0022 next cycle.
- SOF (DEMUX_STREAM_SOF_EN defined):
  - stimulus: mode=1, 2 samples, then a sample with in_sof=1;
  - response: third sample lands on ch0, rr_ptr=1, sof_err=1, no frame_done.
